jtpang_bank_resp: RTL and testbench

//  Memory-side responder for the 4-bank SDRAM request handshake driven by the game
//  (ba_rd/ba*_addr in; ba_ack/ba_dst/ba_dok/ba_rdy/data_read out).
//  - Arbitrates the four bank read requests round-robin.
//  - Serves ROM download writes (prog_*) while downloading is high.
//  - Issues one burst at a time to a single generic memory port.
//  - Sits between the game top level and the SDRAM command engine; also serves as
//    the bank model in simulation.

---
 rtl/jtpang_bank_resp_pkg.sv | 30 +++
 rtl/jtpang_bank_resp_if.sv | 51 +++++
 rtl/jtpang_bank_resp_rr_arb4.sv | 31 +++
 rtl/jtpang_bank_resp.sv | 182 ++++++++++++++++++
 tb/tb_jtpang_bank_resp.sv | 304 ++++++++++++++++++++++++++++++
 5 files changed

// File: rtl/jtpang_bank_resp_pkg.sv
// Shared definitions for the SDRAM bank responder: bank count, FSM encoding
// and the one-hot bank helper.
package jtpang_sdram_pkg;

   localparam int NBANKS = 4;

   // A set bit in a byte mask leaves that byte untouched in memory
   localparam logic MASK_SKIP = 1'b1;

   localparam logic [2:0] ST_IDLE   = 3'd0;
   localparam logic [2:0] ST_RISSUE = 3'd1;
   localparam logic [2:0] ST_RDATA  = 3'd2;
   localparam logic [2:0] ST_WISSUE = 3'd3;
   localparam logic [2:0] ST_WWAIT  = 3'd4;
   localparam logic [2:0] ST_GUARD  = 3'd5;

   typedef enum logic [2:0] {
      IDLE   = ST_IDLE,
      RISSUE = ST_RISSUE,
      RDATA  = ST_RDATA,
      WISSUE = ST_WISSUE,
      WWAIT  = ST_WWAIT,
      GUARD  = ST_GUARD
   } state_t;

   function automatic logic [NBANKS-1:0] bank_onehot(input logic [1:0] b);
      return {{(NBANKS-1){1'b0}}, 1'b1} << b;
   endfunction

endpackage

// File: rtl/jtpang_bank_resp_if.sv
// Game-side bank/download handshake plus the generic memory command port.
// slave is the responder's view, master the view of whoever drives it.
interface jtpang_bank_resp_if #(
   parameter int AW = 22,
   parameter int DW = 16
);
   logic          downloading;
   logic [AW-1:0] ba0_addr;
   logic [AW-1:0] ba1_addr;
   logic [AW-1:0] ba2_addr;
   logic [AW-1:0] ba3_addr;
   logic [3:0]    ba_rd;
   logic [3:0]    ba_ack;
   logic [3:0]    ba_dst;
   logic [3:0]    ba_dok;
   logic [3:0]    ba_rdy;
   logic [DW-1:0] data_read;
   logic [AW-1:0] prog_addr;
   logic [DW-1:0] prog_data;
   logic [1:0]    prog_mask;
   logic [1:0]    prog_ba;
   logic          prog_we;
   logic          prog_ack;
   logic          prog_rdy;
   logic          mem_req;
   logic          mem_we;
   logic [1:0]    mem_ba;
   logic [AW-1:0] mem_addr;
   logic [DW-1:0] mem_din;
   logic [1:0]    mem_din_m;
   logic          mem_gnt;
   logic          mem_dvalid;
   logic [DW-1:0] mem_dout;
   logic          mem_done;

   modport slave (
      input  downloading, ba0_addr, ba1_addr, ba2_addr, ba3_addr, ba_rd,
      input  prog_addr, prog_data, prog_mask, prog_ba, prog_we,
      input  mem_gnt, mem_dvalid, mem_dout, mem_done,
      output ba_ack, ba_dst, ba_dok, ba_rdy, data_read, prog_ack, prog_rdy,
      output mem_req, mem_we, mem_ba, mem_addr, mem_din, mem_din_m
   );

   modport master (
      output downloading, ba0_addr, ba1_addr, ba2_addr, ba3_addr, ba_rd,
      output prog_addr, prog_data, prog_mask, prog_ba, prog_we,
      output mem_gnt, mem_dvalid, mem_dout, mem_done,
      input  ba_ack, ba_dst, ba_dok, ba_rdy, data_read, prog_ack, prog_rdy,
      input  mem_req, mem_we, mem_ba, mem_addr, mem_din, mem_din_m
   );
endinterface

// File: rtl/jtpang_bank_resp_rr_arb4.sv
// Four-input round-robin arbiter: the first requester after ptr (wrapping
// 3->0) wins. Purely combinational.
module jtpang_rr_arb4 (
   input  logic [3:0] req,
   input  logic [1:0] ptr,
   output logic [3:0] gnt,
   output logic [1:0] gnt_id,
   output logic       any
);
   logic [7:0] dbl_s;
   logic [2:0] sh_s;
   logic [3:0] rot_s;
   logic [1:0] off_s;

   // Rotate so that bit 0 is the bank just after ptr, then priority-encode
   always_comb begin
      dbl_s = {req, req};
      sh_s  = {1'b0, ptr} + 3'd1;
      rot_s = 4'(dbl_s >> sh_s);
      casez (rot_s)
         4'b???1: off_s = 2'd0;
         4'b??10: off_s = 2'd1;
         4'b?100: off_s = 2'd2;
         4'b1000: off_s = 2'd3;
         default: off_s = 2'd0;
      endcase
      any    = |req;
      gnt_id = ptr + 2'd1 + off_s;
      gnt    = any ? (4'b0001 << gnt_id) : 4'b0000;
   end
endmodule

// File: rtl/jtpang_bank_resp.sv
// Memory-side responder for the 4-bank SDRAM request handshake: round-robin
// bank reads, download writes, one burst at a time on a single memory port.
module jtpang_bank_resp
   import jtpang_sdram_pkg::*;
#(
   parameter int AW    = 22,
   parameter int DW    = 16,
   parameter int BURST = 2
)(
   input  logic              clk,
   input  logic              rst_n,
   jtpang_bank_resp_if.slave bus
);
   localparam logic [1:0] LAST_WORD = 2'(BURST - 1);

   state_t              state_r;
   logic [1:0]          ptr_r;
   logic [1:0]          bank_r;
   logic [1:0]          cnt_r;
   logic [AW-1:0]       addr_r;
   logic [DW-1:0]       din_r;
   logic [1:0]          mask_r;

   logic [NBANKS-1:0]   ba_ack_r;
   logic [NBANKS-1:0]   ba_dst_r;
   logic [NBANKS-1:0]   ba_dok_r;
   logic [NBANKS-1:0]   ba_rdy_r;
   logic [DW-1:0]       data_read_r;
   logic                prog_ack_r;
   logic                prog_rdy_r;
   logic                mem_req_r;
   logic                mem_we_r;
   logic [1:0]          mem_ba_r;
   logic [AW-1:0]       mem_addr_r;
   logic [DW-1:0]       mem_din_r;
   logic [1:0]          mem_din_m_r;

   logic [NBANKS-1:0]   gnt_s;
   logic [1:0]          gnt_id_s;
   logic                any_s;
   logic [AW-1:0]       sel_addr_s;
   logic [NBANKS-1:0]   bank_oh_s;
   logic                last_s;

   jtpang_rr_arb4 u_arb (
      .req    (bus.ba_rd),
      .ptr    (ptr_r),
      .gnt    (gnt_s),
      .gnt_id (gnt_id_s),
      .any    (any_s)
   );

   // Address of the winning bank and per-burst decode
   always_comb begin
      case (gnt_id_s)
         2'd0:    sel_addr_s = bus.ba0_addr;
         2'd1:    sel_addr_s = bus.ba1_addr;
         2'd2:    sel_addr_s = bus.ba2_addr;
         2'd3:    sel_addr_s = bus.ba3_addr;
         default: sel_addr_s = bus.ba0_addr;
      endcase
      bank_oh_s = bank_onehot(bank_r);
      last_s    = (cnt_r == LAST_WORD);
   end

   // Control FSM with all outputs registered; pulses default low every cycle
   always_ff @(posedge clk) begin
      if (!rst_n) begin
         state_r     <= IDLE;
         ptr_r       <= 2'd3;
         bank_r      <= 2'd0;
         cnt_r       <= 2'd0;
         addr_r      <= '0;
         din_r       <= '0;
         mask_r      <= 2'd0;
         ba_ack_r    <= 4'd0;
         ba_dst_r    <= 4'd0;
         ba_dok_r    <= 4'd0;
         ba_rdy_r    <= 4'd0;
         data_read_r <= '0;
         prog_ack_r  <= 1'b0;
         prog_rdy_r  <= 1'b0;
         mem_req_r   <= 1'b0;
         mem_we_r    <= 1'b0;
         mem_ba_r    <= 2'd0;
         mem_addr_r  <= '0;
         mem_din_r   <= '0;
         mem_din_m_r <= 2'd0;
      end else begin
         ba_ack_r   <= 4'd0;
         ba_dst_r   <= 4'd0;
         ba_dok_r   <= 4'd0;
         ba_rdy_r   <= 4'd0;
         prog_ack_r <= 1'b0;
         prog_rdy_r <= 1'b0;
         case (state_r)
            IDLE: begin
               if (bus.downloading) begin
                  if (bus.prog_we) begin
                     addr_r     <= bus.prog_addr;
                     din_r      <= bus.prog_data;
                     mask_r     <= bus.prog_mask;
                     bank_r     <= bus.prog_ba;
                     prog_ack_r <= 1'b1;
                     state_r    <= WISSUE;
                  end
               end else if (any_s) begin
                  addr_r   <= sel_addr_s;
                  bank_r   <= gnt_id_s;
                  ptr_r    <= gnt_id_s;
                  ba_ack_r <= gnt_s;
                  cnt_r    <= 2'd0;
                  state_r  <= RISSUE;
               end
            end
            RISSUE: begin
               if (!mem_req_r) begin
                  mem_req_r  <= 1'b1;
                  mem_we_r   <= 1'b0;
                  mem_ba_r   <= bank_r;
                  mem_addr_r <= addr_r;
               end else if (bus.mem_gnt) begin
                  mem_req_r <= 1'b0;
                  state_r   <= RDATA;
               end
            end
            // Each returned word is registered; first/last words tag dst/rdy
            RDATA: begin
               if (bus.mem_dvalid) begin
                  data_read_r <= bus.mem_dout;
                  ba_dok_r    <= bank_oh_s;
                  ba_dst_r    <= (cnt_r == 2'd0) ? bank_oh_s : 4'd0;
                  ba_rdy_r    <= last_s ? bank_oh_s : 4'd0;
                  if (last_s) begin
                     cnt_r   <= 2'd0;
                     state_r <= GUARD;
                  end else begin
                     cnt_r <= cnt_r + 2'd1;
                  end
               end
            end
            WISSUE: begin
               if (!mem_req_r) begin
                  mem_req_r   <= 1'b1;
                  mem_we_r    <= 1'b1;
                  mem_ba_r    <= bank_r;
                  mem_addr_r  <= addr_r;
                  mem_din_r   <= din_r;
                  mem_din_m_r <= mask_r;
               end else if (bus.mem_gnt) begin
                  mem_req_r <= 1'b0;
                  mem_we_r  <= 1'b0;
                  state_r   <= WWAIT;
               end
            end
            WWAIT: begin
               if (bus.mem_done) begin
                  prog_rdy_r <= 1'b1;
                  state_r    <= GUARD;
               end
            end
            GUARD:   state_r <= IDLE;
            default: state_r <= IDLE;
         endcase
      end
   end

   assign bus.ba_ack    = ba_ack_r;
   assign bus.ba_dst    = ba_dst_r;
   assign bus.ba_dok    = ba_dok_r;
   assign bus.ba_rdy    = ba_rdy_r;
   assign bus.data_read = data_read_r;
   assign bus.prog_ack  = prog_ack_r;
   assign bus.prog_rdy  = prog_rdy_r;
   assign bus.mem_req   = mem_req_r;
   assign bus.mem_we    = mem_we_r;
   assign bus.mem_ba    = mem_ba_r;
   assign bus.mem_addr  = mem_addr_r;
   assign bus.mem_din   = mem_din_r;
   assign bus.mem_din_m = mem_din_m_r;

endmodule

// File: tb/tb_jtpang_bank_resp.sv
// Bench for jtpang_bank_resp: vector table of bank reads, scoreboard on the
// returned words, and hand sequences for writes, reset abort and BURST=1.
module tb_jtpang_bank_resp;

   logic clk;
   logic rst_n;

   jtpang_bank_resp_if #(.AW(22), .DW(16)) bi  ();
   jtpang_bank_resp_if #(.AW(22), .DW(16)) bi1 ();

   jtpang_bank_resp #(.AW(22), .DW(16), .BURST(2)) dut  (.clk(clk), .rst_n(rst_n), .bus(bi));
   jtpang_bank_resp #(.AW(22), .DW(16), .BURST(1)) dut1 (.clk(clk), .rst_n(rst_n), .bus(bi1));

   initial begin
      clk = 1'b0;
      forever #5 clk = ~clk;
   end

   typedef struct {
      logic [3:0]  rd;
      logic [1:0]  bank;
      int          dly;
      logic [15:0] w0;
      logic [15:0] w1;
      bit          b2b;
   } vec_t;

   typedef struct {
      logic [3:0]  oh;
      logic [15:0] data;
      logic        dst;
      logic        rdy;
   } word_t;

   vec_t  vecs [10];
   word_t sb [$];
   int    n_chk  = 0;
   int    n_fail = 0;
   int    ack_cnt [4] = '{0, 0, 0, 0};
   int    exp_ack [4] = '{0, 0, 0, 0};

   task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
      n_chk++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
      end
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   function automatic logic [3:0] oh(input logic [1:0] b);
      logic [3:0] one;
      one = 4'b0001;
      return one << b;
   endfunction

   function automatic logic [21:0] addr_of(input int n, input int i);
      return 22'h1234 + 22'(n * 32'h10000) + 22'(i * 32'h100);
   endfunction

   task automatic chk_zero(input string name);
      chk({name, "_bank"}, {bi.ba_ack, bi.ba_dst, bi.ba_dok, bi.ba_rdy, bi.data_read,
                            bi.prog_ack, bi.prog_rdy}, 64'd0);
      chk({name, "_mem"}, {bi.mem_req, bi.mem_we, bi.mem_ba, bi.mem_addr, bi.mem_din,
                           bi.mem_din_m}, 64'd0);
   endtask

   task automatic set_addrs(input int i);
      bi.ba0_addr = addr_of(0, i);
      bi.ba1_addr = addr_of(1, i);
      bi.ba2_addr = addr_of(2, i);
      bi.ba3_addr = addr_of(3, i);
   endtask

   task automatic push(input logic [1:0] b, input logic [15:0] d, input logic dst, input logic rdy);
      word_t e;
      e.oh = oh(b); e.data = d; e.dst = dst; e.rdy = rdy;
      sb.push_back(e);
   endtask

   // ba_rd already driven with IDLE sampling next edge; serves one 2-word burst
   task automatic do_read(input logic [1:0] b, input logic [21:0] a, input int dly,
                          input logic [15:0] w0, input logic [15:0] w1, input bit b2b,
                          input bit mid_dl, input logic [3:0] pend);
      tick();
      chk("ba_ack", bi.ba_ack, oh(b));
      chk("req_early", bi.mem_req, 1'b0);
      exp_ack[b]++;
      bi.ba0_addr = 22'h3FFFFF; bi.ba1_addr = 22'h3FFFFF;
      bi.ba2_addr = 22'h3FFFFF; bi.ba3_addr = 22'h3FFFFF;
      tick();
      chk("ack_single", bi.ba_ack, 4'd0);
      chk("rd_req", {bi.mem_req, bi.mem_we}, 2'b10);
      chk("rd_ba", bi.mem_ba, b);
      chk("rd_addr", bi.mem_addr, a);
      for (int k = 0; k < dly; k++) begin
         tick();
         chk("req_hold", bi.mem_req, 1'b1);
      end
      bi.mem_gnt = 1'b1;
      tick();
      bi.mem_gnt = 1'b0;
      chk("req_drop", bi.mem_req, 1'b0);
      bi.mem_dvalid = 1'b1; bi.mem_dout = w0;
      push(b, w0, 1'b1, 1'b0);
      tick();
      bi.mem_dvalid = 1'b0;
      if (mid_dl) begin
         bi.downloading = 1'b1;
         bi.ba_rd = bi.ba_rd | pend;
      end
      if (!b2b) tick();
      bi.mem_dvalid = 1'b1; bi.mem_dout = w1;
      push(b, w1, 1'b0, 1'b1);
      tick();
      bi.mem_dvalid = 1'b0;
      bi.ba_rd[b] = 1'b0;
      tick();
   endtask

   // Scoreboard / ack counter on the BURST=2 instance
   always @(negedge clk) begin
      word_t e;
      for (int n = 0; n < 4; n++) ack_cnt[n] += int'(bi.ba_ack[n]);
      if (bi.ba_dok != 4'd0) begin
         chk("dok_onehot", 64'($countones(bi.ba_dok) <= 1), 64'd1);
         if (sb.size() == 0) begin
            chk("dok_unexpected", bi.ba_dok, 4'd0);
         end else begin
            e = sb.pop_front();
            chk("dok", bi.ba_dok, e.oh);
            chk("data_read", bi.data_read, e.data);
            chk("dst", bi.ba_dst, e.dst ? e.oh : 4'd0);
            chk("rdy", bi.ba_rdy, e.rdy ? e.oh : 4'd0);
         end
      end else if ((bi.ba_dst | bi.ba_rdy) != 4'd0) begin
         chk("dst_rdy_no_dok", {bi.ba_dst, bi.ba_rdy}, 8'd0);
      end
   end

   initial begin
      vecs[0] = '{4'b0001, 2'd0, 3, 16'hA5A5, 16'h5A5A, 1'b0};
      vecs[1] = '{4'b1111, 2'd1, 0, 16'h1111, 16'h2222, 1'b0};
      vecs[2] = '{4'b1111, 2'd2, 1, 16'h3333, 16'h4444, 1'b1};
      vecs[3] = '{4'b1111, 2'd3, 2, 16'h5555, 16'h6666, 1'b0};
      vecs[4] = '{4'b1111, 2'd0, 0, 16'h7777, 16'h8888, 1'b1};
      vecs[5] = '{4'b1010, 2'd1, 1, 16'h9999, 16'hAAAA, 1'b0};
      vecs[6] = '{4'b1010, 2'd3, 0, 16'hBBBB, 16'hCCCC, 1'b1};
      vecs[7] = '{4'b0100, 2'd2, 2, 16'hDDDD, 16'hEEEE, 1'b0};
      vecs[8] = '{4'b1001, 2'd3, 0, 16'h0F0F, 16'hF0F0, 1'b1};
      vecs[9] = '{4'b1001, 2'd0, 1, 16'h1357, 16'h2468, 1'b0};

      rst_n = 1'b0;
      bi.downloading = 1'b0; bi.ba_rd = 4'd0; set_addrs(0);
      bi.prog_addr = 22'd0; bi.prog_data = 16'd0; bi.prog_mask = 2'd0;
      bi.prog_ba = 2'd0; bi.prog_we = 1'b0;
      bi.mem_gnt = 1'b0; bi.mem_dvalid = 1'b0; bi.mem_dout = 16'd0; bi.mem_done = 1'b0;
      bi1.downloading = 1'b0; bi1.ba_rd = 4'd0;
      bi1.ba0_addr = 22'd0; bi1.ba1_addr = 22'd0; bi1.ba2_addr = 22'd0; bi1.ba3_addr = 22'd0;
      bi1.prog_addr = 22'd0; bi1.prog_data = 16'd0; bi1.prog_mask = 2'd0;
      bi1.prog_ba = 2'd0; bi1.prog_we = 1'b0;
      bi1.mem_gnt = 1'b0; bi1.mem_dvalid = 1'b0; bi1.mem_dout = 16'd0; bi1.mem_done = 1'b0;
      repeat (3) tick();
      chk_zero("reset");
      rst_n = 1'b1;

      // Round-robin read table, bank 0 first out of reset
      for (int i = 0; i < 10; i++) begin
         set_addrs(i);
         bi.ba_rd = vecs[i].rd;
         do_read(vecs[i].bank, addr_of(vecs[i].bank, i), vecs[i].dly,
                 vecs[i].w0, vecs[i].w1, vecs[i].b2b, 1'b0, 4'd0);
      end

      // downloading rises mid-read; bank 3 held off until it falls
      set_addrs(20);
      bi.ba_rd = 4'b0001;
      do_read(2'd0, addr_of(0, 20), 1, 16'hC0DE, 16'hFACE, 1'b0, 1'b1, 4'b1000);
      for (int k = 0; k < 3; k++) begin
         tick();
         chk("dl_holdoff", bi.ba_ack, 4'd0);
      end
      set_addrs(21);
      bi.downloading = 1'b0;
      do_read(2'd3, addr_of(3, 21), 0, 16'h0BAD, 16'hCAFE, 1'b1, 1'b0, 4'd0);

      // Download write; bank 1 request must not be acked
      bi.downloading = 1'b1;
      bi.prog_addr = 22'h10; bi.prog_data = 16'hBEEF; bi.prog_mask = 2'b01;
      bi.prog_ba = 2'd2; bi.prog_we = 1'b1; bi.ba_rd = 4'b0010;
      tick();
      chk("prog_ack", bi.prog_ack, 1'b1);
      tick();
      chk("prog_ack_single", bi.prog_ack, 1'b0);
      chk("wr_req", {bi.mem_req, bi.mem_we}, 2'b11);
      chk("wr_ba", bi.mem_ba, 2'd2);
      chk("wr_addr", bi.mem_addr, 22'h10);
      chk("wr_din", bi.mem_din, 16'hBEEF);
      chk("wr_mask", bi.mem_din_m, 2'b01);
      tick();
      chk("wr_req_hold", bi.mem_req, 1'b1);
      bi.mem_gnt = 1'b1;
      tick();
      bi.mem_gnt = 1'b0;
      chk("wr_req_drop", bi.mem_req, 1'b0);
      repeat (2) tick();
      chk("prog_rdy_early", bi.prog_rdy, 1'b0);
      bi.mem_done = 1'b1;
      tick();
      bi.mem_done = 1'b0;
      chk("prog_rdy", bi.prog_rdy, 1'b1);
      bi.prog_we = 1'b0;
      tick();
      chk("prog_rdy_single", bi.prog_rdy, 1'b0);
      repeat (2) tick();
      bi.ba_rd = 4'd0;

      // Second write with downloading dropping mid-write; stray dvalid in WWAIT
      bi.prog_addr = 22'h20; bi.prog_data = 16'h1357; bi.prog_mask = 2'b10;
      bi.prog_ba = 2'd1; bi.prog_we = 1'b1;
      tick();
      chk("prog_ack2", bi.prog_ack, 1'b1);
      tick();
      chk("wr2_cmd", {bi.mem_we, bi.mem_ba, bi.mem_din_m}, {1'b1, 2'd1, 2'b10});
      bi.mem_gnt = 1'b1;
      tick();
      bi.mem_gnt = 1'b0;
      bi.downloading = 1'b0;
      bi.mem_dvalid = 1'b1; bi.mem_dout = 16'hFFFF;
      tick();
      bi.mem_dvalid = 1'b0;
      bi.mem_done = 1'b1;
      tick();
      bi.mem_done = 1'b0;
      chk("prog_rdy2", bi.prog_rdy, 1'b1);
      bi.prog_we = 1'b0;
      tick();
      bi.prog_we = 1'b1;
      tick();
      chk("prog_ignored", bi.prog_ack, 1'b0);
      tick();
      chk("prog_ignored_req", bi.mem_req, 1'b0);
      bi.prog_we = 1'b0;

      // Reset abandons a bank-2 burst after its first word
      set_addrs(30);
      bi.ba_rd = 4'b0100;
      tick();
      chk("rst_ack2", bi.ba_ack, 4'b0100);
      exp_ack[2]++;
      tick();
      chk("rst_req", bi.mem_req, 1'b1);
      bi.mem_gnt = 1'b1;
      tick();
      bi.mem_gnt = 1'b0;
      bi.mem_dvalid = 1'b1; bi.mem_dout = 16'h4444;
      push(2'd2, 16'h4444, 1'b1, 1'b0);
      tick();
      bi.mem_dout = 16'h9999;
      rst_n = 1'b0;
      bi.ba_rd = 4'd0;
      tick();
      chk_zero("midburst_reset");
      rst_n = 1'b1;
      tick();
      bi.mem_dvalid = 1'b0;
      set_addrs(31);
      bi.ba_rd = 4'b1111;
      do_read(2'd0, addr_of(0, 31), 0, 16'h6001, 16'h6002, 1'b0, 1'b0, 4'd0);
      bi.ba_rd = 4'd0;

      // BURST=1 instance: dst/dok/rdy together, then GUARD before the next grant
      bi1.ba1_addr = 22'h77;
      bi1.ba_rd = 4'b0010;
      tick();
      chk("b1_ack", bi1.ba_ack, 4'b0010);
      tick();
      chk("b1_req", {bi1.mem_req, bi1.mem_addr}, {1'b1, 22'h77});
      bi1.mem_gnt = 1'b1;
      tick();
      bi1.mem_gnt = 1'b0;
      bi1.mem_dvalid = 1'b1; bi1.mem_dout = 16'h0042;
      tick();
      bi1.mem_dvalid = 1'b0;
      chk("b1_flags", {bi1.ba_dst, bi1.ba_dok, bi1.ba_rdy}, {4'b0010, 4'b0010, 4'b0010});
      chk("b1_data", bi1.data_read, 16'h0042);
      bi1.ba_rd = 4'b0001;
      tick();
      chk("b1_guard", {bi1.ba_ack, bi1.ba_dok}, 8'd0);
      tick();
      chk("b1_next_ack", bi1.ba_ack, 4'b0001);

      tick();
      for (int n = 0; n < 4; n++) chk($sformatf("ack_count%0d", n), 64'(ack_cnt[n]), 64'(exp_ack[n]));
      chk("sb_empty", 64'(sb.size()), 64'd0);
      $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
      $finish;
   end

endmodule
